// File: rtl/snn_addr_counter_pkg.sv
// Shared sizing helpers for the SNN weight-memory address logic.
package snn_addr_counter_pkg;

  localparam int unsigned AddrWidth = 32;

  // Bits needed to index `value` distinct words.
  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned width;
    width = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < value) width = unsigned'(i) + 1;
    end
    return width;
  endfunction

  function automatic longint unsigned max3(input longint unsigned a,
                                           input longint unsigned b,
                                           input longint unsigned c);
    longint unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/snn_addr_counter.sv
// Write-address counter for weight memories: clear, increment, wrap at DEPTH-1.
module snn_addr_counter
  import snn_addr_counter_pkg::*;
#(
  parameter longint unsigned DEPTH = 8192
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [AddrWidth-1:0] addr
);

  localparam int unsigned AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [AW-1:0] CntMax = AW'(DEPTH - 64'd1);

  if (DEPTH < 64'd2) begin : g_depth_too_small
    $error("snn_addr_counter: DEPTH must be at least 2");
  end
  if (DEPTH > 64'h8000_0000) begin : g_depth_too_large
    $error("snn_addr_counter: DEPTH must not exceed 2^31");
  end

  logic [AW-1:0] cnt_q, cnt_d;

  // Explicit compare so non-power-of-two depths wrap at DEPTH-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign addr = AddrWidth'(cnt_q);

`ifndef SYNTHESIS
  a_cnt_range: assert property (@(posedge clk) disable iff (rst) 64'(cnt_q) < DEPTH);
  a_addr_upper: assert property (@(posedge clk) disable iff (rst) (addr >> AW) == 32'd0);
  a_clr_zero: assert property (@(posedge clk) disable iff (rst) clr |=> addr == 32'd0);
  a_inc_step: assert property (@(posedge clk) disable iff (rst)
    (inc && !clr) |=> cnt_q == (($past(cnt_q) == CntMax) ? '0 : $past(cnt_q) + AW'(1)));
  a_known_ctrl: assert property (@(posedge clk) !rst |-> !$isunknown({clr, inc}));
`endif

endmodule

// File: tb/tb_snn_addr_counter.sv
// Scoreboard bench for snn_addr_counter at DEPTH=8192 and DEPTH=5.
module tb_snn_addr_counter;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        clr, inc;
  logic        clr5, inc5;
  logic [31:0] addr8k, addr5;

  int vectors;
  int miscompares;

  exp_t q8k[$];
  exp_t q5[$];

  snn_addr_counter #(.DEPTH(8192)) u_dut8k (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (inc),
    .addr (addr8k)
  );

  snn_addr_counter #(.DEPTH(5)) u_dut5 (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr5),
    .inc  (inc5),
    .addr (addr5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%h), required %0d (0x%h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // One vector on the 8192-deep counter: inputs for the coming edge and the address after it.
  task automatic step8k(input string name, input logic c, input logic i, input logic [31:0] e);
    exp_t x;
    @(negedge clk);
    clr = c;
    inc = i;
    x.name = name;
    x.exp  = e;
    q8k.push_back(x);
  endtask

  task automatic step5(input string name, input logic c, input logic i, input logic [31:0] e);
    exp_t x;
    @(negedge clk);
    clr5 = c;
    inc5 = i;
    x.name = name;
    x.exp  = e;
    q5.push_back(x);
  endtask

  // Monitor: the counter presents a new address after every rising edge.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q8k.size() > 0) begin
      x = q8k.pop_front();
      check(x.name, addr8k, x.exp);
    end
    if (q5.size() > 0) begin
      x = q5.pop_front();
      check(x.name, addr5, x.exp);
    end
  end

  logic [31:0] wrap5_tbl [12];

  initial begin
    vectors     = 0;
    miscompares = 0;
    wrap5_tbl   = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0,
                    32'd1, 32'd2};
    rst  = 1'b0;
    clr  = 1'b0;
    inc  = 1'b0;
    clr5 = 1'b0;
    inc5 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_addr8k", addr8k, 32'd0);
    check("reset_addr5", addr5, 32'd0);

    // inc ignored while rst is high
    step8k("rst_ignores_inc", 1'b0, 1'b1, 32'd0);
    step8k("rst_ignores_inc", 1'b0, 1'b1, 32'd0);

    // First edge after release counts; 10 increments then 3 holds
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 1) begin
        exp_t x;
        inc = 1'b1;
        x.name = "inc_first";
        x.exp  = 32'd1;
        q8k.push_back(x);
      end else begin
        step8k("inc_run", 1'b0, 1'b1, 32'(i));
      end
    end
    for (int i = 0; i < 3; i++) step8k("inc_hold", 1'b0, 1'b0, 32'd10);

    // Clear priority at address 7
    step8k("clr_alone", 1'b1, 1'b0, 32'd0);
    for (int i = 1; i <= 7; i++) step8k("count_to_7", 1'b0, 1'b1, 32'(i));
    step8k("clr_beats_inc", 1'b1, 1'b1, 32'd0);
    step8k("inc_after_clr", 1'b0, 1'b1, 32'd1);

    // Clear held with inc toggling
    for (int i = 0; i < 4; i++) step8k("clr_hold", 1'b1, 1'(i % 2 == 0), 32'd0);
    step8k("idle_after_clr", 1'b0, 1'b0, 32'd0);

    // Count to 5, then assert rst mid-cycle
    for (int i = 1; i <= 5; i++) step8k("count_to_5", 1'b0, 1'b1, 32'(i));
    step8k("hold_5", 1'b0, 1'b0, 32'd5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_midcycle", addr8k, 32'd0);
    for (int i = 0; i < 3; i++) step8k("rst_held_inc", 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    inc = 1'b0;

    // Power-of-two wrap
    step8k("wrap8k_clr", 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 8192; i++) step8k("wrap8k", 1'b0, 1'b1, 32'((i + 1) % 8192));
    step8k("wrap8k_hold", 1'b0, 1'b0, 32'd0);

    // Non-power-of-two wrap on the DEPTH=5 instance
    step5("wrap5_clr", 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 12; i++) step5("wrap5", 1'b0, 1'b1, wrap5_tbl[i]);
    step5("wrap5_hold", 1'b0, 1'b0, 32'd2);

    // Drain the scoreboard
    repeat (3) @(negedge clk);
    check("q8k_drained", 32'(q8k.size()), 32'd0);
    check("q5_drained", 32'(q5.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
